shifter_2d: RTL and testbench



---
 rtl/shifter_pkg.sv | 10 +
 rtl/shifter_2d_if.sv | 24 ++
 rtl/shifter_stage.sv | 27 ++
 rtl/shifter_2d.sv | 32 +++
 tb/tb_shifter_2d.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared types and default geometry for the enable-gated 2D shift register.
package shifter_pkg;

  localparam int unsigned SHIFT_WIDTH = 8;
  localparam int unsigned SHIFT_DEPTH = 4;

  typedef logic [SHIFT_WIDTH-1:0] word_t;
  typedef word_t [SHIFT_DEPTH-1:0] stage_array_t;

endpackage

// File: rtl/shifter_2d_if.sv
// Data/enable bundle between a producer and the shift-register delay line.
interface shifter_2d_if
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH
) ();

  logic             enable;
  logic [WIDTH-1:0] es;
  logic [WIDTH-1:0] ss;

  modport master (
    output enable,
    output es,
    input  ss
  );

  modport slave (
    input  enable,
    input  es,
    output ss
  );

endinterface

// File: rtl/shifter_stage.sv
// One WIDTH-bit delay-line stage: synchronous active-low clear, then load enable.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Clear wins over load so a reset edge never captures the incoming word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/shifter_2d.sv
// Enable-gated DEPTH x WIDTH delay line; SS is the registered output of the last stage.
module shifter_2d
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH,
  parameter int unsigned DEPTH = SHIFT_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  shifter_2d_if.slave    bus
);

  // chain[0] is the input word; chain[i+1] is the output of stage i.
  logic [DEPTH:0][WIDTH-1:0] chain;

  assign chain[0] = bus.es;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.enable),
      .d     (chain[i]),
      .q     (chain[i+1])
    );
  end

  assign bus.ss = chain[DEPTH];

endmodule

// File: tb/tb_shifter_2d.sv
// Self-checking bench: history-queue model of the delay line plus directed literal checks.
module tb_shifter_2d;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  shifter_2d_if #(.WIDTH(W)) bus ();

  shifter_2d #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: words accepted since the last reset, newest at the back, trimmed to D.
  // SS must be the word accepted D enabled edges ago, or 0 if fewer have been accepted.
  logic [W-1:0] hist[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
    end else if (bus.enable) begin
      hist.push_back(bus.es);
      if (hist.size() > D) void'(hist.pop_front());
    end
  end

  function automatic logic [W-1:0] model_ss();
    if (hist.size() == D) return hist[0];
    return '0;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare just after the edge, then confirm SS is unchanged 1ns before
  // the next edge, after the inputs have moved.
  always @(posedge clk) begin
    logic [W-1:0] sampled;
    #1;
    sampled = bus.ss;
    check("model", sampled, model_ss());
    #8;
    check("stable", bus.ss, sampled);
  end

  task automatic step(input logic rst, input logic en, input logic [W-1:0] data);
    @(negedge clk);
    rst_n      = rst;
    bus.enable = en;
    bus.es     = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int idx;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.es     = '0;

    // Reset held for 5 edges
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", bus.ss, 8'h00);
    end

    // Single one with a 2-edge stall: appears on the 4th enabled edge only
    step(1'b1, 1'b1, 8'h01);
    check("one_e1", bus.ss, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("one_stall", bus.ss, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    check("one_e2", bus.ss, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    check("one_e3", bus.ss, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    check("one_e4", bus.ss, 8'h01);
    step(1'b1, 1'b1, 8'h00);
    check("one_gone", bus.ss, 8'h00);

    // Back-to-back stream
    step(1'b1, 1'b1, 8'd5);
    step(1'b1, 1'b1, 8'd7);
    step(1'b1, 1'b1, 8'd48);
    step(1'b1, 1'b1, 8'd0);
    check("stream_5", bus.ss, 8'd5);
    step(1'b1, 1'b1, 8'd0);
    check("stream_7", bus.ss, 8'd7);
    step(1'b1, 1'b1, 8'd0);
    check("stream_48", bus.ss, 8'd48);

    // Random enable with 5 consecutive values; the model checks order and timing
    base = int'($urandom_range(1, 250));
    idx  = 0;
    while (idx < 5) begin
      logic en;
      en = 1'($urandom_range(0, 1));
      step(1'b1, en, W'(base - 1 + idx));
      if (en) idx++;
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 8'h00);

    // Reset mid-stream with enable high and ES=FF at the reset edge
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b1, 8'h44);
    check("pre_reset", bus.ss, 8'h11);
    step(1'b0, 1'b1, 8'hFF);
    check("mid_reset", bus.ss, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'h00);
      check("post_reset", bus.ss, 8'h00);
    end

    // Fully random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), 1'($urandom_range(0, 1)), W'($urandom));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
